// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the instruction-fetch stage.
//   fetch_state_e  : fetch FSM state encoding
//   DefaultResetPc : default address of the first fetch after reset
//   Nop            : instruction word presented on a bubble
package if_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StHold  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop            = 32'h0000_0000;
  localparam logic [31:0] PcStep         = 32'd4;

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter register with +4 increment and redirect mux.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset, loads RESET_PC
//   load_i   : redirect to target_i (takes priority over inc_i)
//   target_i : redirect address; bits [1:0] are forced to zero
//   inc_i    : advance by one word (wraps modulo 2^32)
//   pc_o     : current program counter
module pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ~32'h0000_0003;
    end else if (inc_i) begin
      pc_d = pc_q + PcStep;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word fetches to instruction memory and
// registers the returned instruction towards the IF/ID stage.
//   clk, reset            : clock, asynchronous active-high reset
//   stall                 : downstream stall
//   branch_flag/_target   : one-cycle redirect request and its target
//   imem_req/_addr        : memory request (level) and word address
//   imem_ack/_rdata       : request completion and returned instruction
//   if_pc/if_inst/if_valid: registered fetch result (if_valid=0 is a bubble)
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_e state_d, state_q;
  logic [31:0]  if_pc_d, if_pc_q;
  logic [31:0]  if_inst_d, if_inst_q;
  logic         if_valid_d, if_valid_q;
  // Address of the request still outstanding when a branch redirected pc.
  logic [31:0]  drain_addr_d, drain_addr_q;
  logic         pc_load, pc_inc;
  logic [31:0]  pc;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (pc_load),
    .target_i(branch_target),
    .inc_i   (pc_inc),
    .pc_o    (pc)
  );

  always_comb begin
    state_d      = state_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;
    drain_addr_d = drain_addr_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;

    // A branch always squashes the stage output, whatever the state.
    if (branch_flag) begin
      pc_load    = 1'b1;
      if_inst_d  = Nop;
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (branch_flag) begin
          if (!imem_ack) begin
            // Request cannot be withdrawn: finish it at the old address.
            state_d      = StDrain;
            drain_addr_d = pc;
          end
        end else if (imem_ack) begin
          if_pc_d    = pc;
          if_inst_d  = imem_rdata;
          if_valid_d = 1'b1;
          pc_inc     = 1'b1;
          state_d    = stall ? StHold : StFetch;
        end else if (!stall) begin
          if_inst_d  = Nop;
          if_valid_d = 1'b0;
        end
      end
      StDrain: begin
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      StHold: begin
        if (branch_flag || !stall) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      if_pc_q      <= 32'h0;
      if_inst_q    <= Nop;
      if_valid_q   <= 1'b0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_valid_q   <= if_valid_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign imem_req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr = (state_q == StDrain) ? drain_addr_q : pc;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, branch_flag, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_inst;
  logic        imem_req_w, if_valid_w;
  logic [31:0] imem_addr_w, if_pc_w, if_inst_w;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .if_valid(if_valid)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc_w), .if_inst(if_inst_w),
    .if_valid(if_valid_w)
  );

  // Reference model (for dut, RESET_PC = 0), described as a request stream:
  // started  - the one idle cycle after reset has elapsed
  // parked   - an instruction was delivered under stall; no request until released
  // discard  - the outstanding request was overtaken by a branch
  bit          m_started, m_parked, m_discard;
  logic [31:0] m_pc, m_old_addr, m_if_pc, m_if_inst;
  bit          m_if_valid;

  function automatic void model_reset();
    m_started = 0; m_parked = 0; m_discard = 0;
    m_pc = 32'h0; m_old_addr = 32'h0;
    m_if_pc = 32'h0; m_if_inst = 32'h0; m_if_valid = 0;
  endfunction

  function automatic bit model_req();
    return m_started && !m_parked;
  endfunction

  function automatic void model_step(bit br, logic [31:0] tgt, bit st, bit ak,
                                     logic [31:0] rd);
    bit requesting;
    requesting = model_req();
    if (br) begin
      m_if_inst = 32'h0; m_if_valid = 0;
      if (requesting && !ak && !m_discard) begin
        m_discard = 1; m_old_addr = m_pc;
      end else if (requesting && ak) begin
        m_discard = 0;
      end
      m_pc = {tgt[31:2], 2'b00};
      m_parked = 0;
    end else if (!m_started) begin
      // idle cycle
    end else if (m_parked) begin
      if (!st) m_parked = 0;
    end else if (ak) begin
      if (m_discard) begin
        m_discard = 0;
      end else begin
        m_if_pc = m_pc; m_if_inst = rd; m_if_valid = 1;
        m_pc = m_pc + 32'd4;
        m_parked = st;
      end
    end else if (!m_discard && !st) begin
      m_if_inst = 32'h0; m_if_valid = 0;
    end
    m_started = 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("imem_req", 32'(imem_req), 32'(model_req()));
    if (model_req()) check("imem_addr", imem_addr, m_discard ? m_old_addr : m_pc);
    check("if_pc", if_pc, m_if_pc);
    check("if_inst", if_inst, m_if_inst);
    check("if_valid", 32'(if_valid), 32'(m_if_valid));
  endtask

  // Called at a falling edge: check, drive, advance the model, wait one cycle.
  task automatic cycle(input bit br, input logic [31:0] tgt, input bit st, input bit ak,
                       input logic [31:0] rd);
    check_outputs();
    branch_flag = br; branch_target = tgt; stall = st; imem_ack = ak; imem_rdata = rd;
    model_step(br, tgt, st, ak, rd);
    @(negedge clk);
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'h0, 0, 1, $urandom);
  endtask

  // Asynchronous reset placed between clock edges, with an ack held during it.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
    imem_ack = 1'b0; branch_flag = 1'b0; stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_flag = 1'b0; imem_ack = 1'b0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle cycle, then back-to-back fetches 0x0, 0x4, 0x8.
    cycle(0, 32'h0, 0, 0, 32'h0);
    ack_n(3);
    check("seq_if_pc", if_pc, 32'h8);
    check("seq_if_valid", 32'(if_valid), 32'h1);
    check("seq_next_addr", imem_addr, 32'hC);
    ack_n(1);

    // Delayed ack at 0x10.
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 0, 32'h0);
    check("wait_addr", imem_addr, 32'h10);
    check("wait_bubble", 32'(if_valid), 32'h0);
    cycle(0, 32'h0, 0, 1, 32'h1234_5678);
    check("wait_if_pc", if_pc, 32'h10);
    check("wait_if_inst", if_inst, 32'h1234_5678);
    ack_n(3);

    // Stall on the ack of 0x20.
    cycle(0, 32'h0, 1, 1, 32'hCAFE_0020);
    check("stall_if_pc", if_pc, 32'h20);
    check("stall_req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 1, 0, 32'h0);
    check("stall_held_pc", if_pc, 32'h20);
    cycle(0, 32'h0, 0, 0, 32'h0);
    check("stall_release_addr", imem_addr, 32'h24);
    ack_n(3);

    // Branch while 0x30 is outstanding; target low bits must be dropped.
    cycle(1, 32'h0000_0103, 0, 0, 32'h0);
    check("drain_addr", imem_addr, 32'h30);
    check("drain_valid", 32'(if_valid), 32'h0);
    cycle(0, 32'h0, 0, 0, 32'h0);
    cycle(0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    check("drain_discard", 32'(if_valid), 32'h0);
    check("drain_next_addr", imem_addr, 32'h100);
    cycle(0, 32'h0, 0, 1, 32'h0000_0AAA);
    check("drain_if_pc", if_pc, 32'h100);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 600; i++) begin
      bit br, st, ak;
      if (i == 300) do_reset();
      br = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      ak = model_req() && ($urandom_range(0, 2) != 0);
      cycle(br, $urandom, st, ak, $urandom);
    end

    // Wrap-around from RESET_PC = 0xFFFF_FFFC.
    do_reset();
    cycle(0, 32'h0, 0, 0, 32'h0);
    check("wrap_first_addr", imem_addr_w, 32'hFFFF_FFFC);
    cycle(0, 32'h0, 0, 1, 32'h0000_1111);
    check("wrap_second_addr", imem_addr_w, 32'h0000_0000);
    check("wrap_if_pc", if_pc_w, 32'hFFFF_FFFC);
    cycle(0, 32'h0, 0, 1, 32'h0000_2222);
    check("wrap_third_addr", imem_addr_w, 32'h0000_0004);
    check("wrap_if_inst", if_inst_w, 32'h0000_2222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
